// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register: load, shift, and (optionally) rotate
// with bit capture. Define USR_SEQ_ROT_EN to enable the rotate ops (011/100).
module usr_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] usr_po,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_pi,
  output logic             usr_si,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] shifted_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  logic [1:0]       r_state;
  logic             r_ready;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_fill;
  logic             r_err;
  logic [WIDTH-1:0] r_so;

  logic [1:0]       w_next;
  logic             w_accept;
  logic             w_legal;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_left;
  logic             w_exit;
  logic             w_si;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    if (int'(c) > WIDTH) return CNT_W'(WIDTH);
    else return c;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_LOAD, OP_SHL, OP_SHR: return 1'b1;
`ifdef USR_SEQ_ROT_EN
      OP_ROL, OP_ROR:          return 1'b1;
`endif
      default:                 return 1'b0;
    endcase
  endfunction

  assign w_accept  = cmd_valid && r_ready;
  assign w_legal   = op_legal(cmd_op);
  assign w_cnt_sat = sat_cnt(cmd_cnt);

`ifdef USR_SEQ_ROT_EN
  assign w_left = (r_op == OP_SHL) || (r_op == OP_ROL);
`else
  assign w_left = (r_op == OP_SHL);
`endif
  assign w_exit = w_left ? usr_po[WIDTH-1] : usr_po[0];

  // Rotate feeds the exiting bit straight back in; shifts use the latched fill bit.
  always_comb begin
    w_si = 1'b0;
    if (r_state == S_SHIFT) begin
`ifdef USR_SEQ_ROT_EN
      case (r_op)
        OP_ROL:  w_si = usr_po[WIDTH-1];
        OP_ROR:  w_si = usr_po[0];
        default: w_si = r_fill;
      endcase
`else
      w_si = r_fill;
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_legal)                w_next = S_DONE;
          else if (cmd_op == OP_LOAD)  w_next = S_LOAD;
          else if (w_cnt_sat == '0)    w_next = S_DONE;
          else                         w_next = S_SHIFT;
        end
      end
      S_LOAD:  w_next = S_DONE;
      S_SHIFT: w_next = (r_cnt == CNT_W'(1)) ? S_DONE : S_SHIFT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_fill  <= 1'b0;
      r_err   <= 1'b0;
      r_so    <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      if (w_accept) begin
        r_op   <= cmd_op;
        r_cnt  <= w_cnt_sat;
        r_data <= cmd_data;
        r_fill <= cmd_fill;
        r_err  <= !w_legal;
        r_so   <= '0;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_so  <= {r_so[WIDTH-2:0], w_exit};
      end
    end
  end

  always_comb begin
    usr_sel = 2'b00;
    case (r_state)
      S_LOAD:  usr_sel = 2'b11;
      S_SHIFT: usr_sel = w_left ? 2'b01 : 2'b10;
      default: usr_sel = 2'b00;
    endcase
  end

  assign cmd_ready   = r_ready;
  assign usr_pi      = r_data;
  assign usr_si      = w_si;
  assign done        = (r_state == S_DONE);
  assign err         = (r_state == S_DONE) && r_err;
  assign shifted_out = r_so;

endmodule
